// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 64-bit single-cycle-latency ALU with registered result and flags
module alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [3:0]  OP,
  input  logic        in_valid,
  output logic [63:0] O,
  output logic        Ovf,
  output logic        Zero,
  output logic        out_valid
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [63:0] sum;
  logic [63:0] diff;
  logic [5:0]  shamt;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [63:0] result;
  logic        result_ovf;

  // Shared arithmetic: wrap-around add/sub, shift amount, and true compares.
  // The signed compare uses $signed directly so it stays correct when A-B overflows.
  always_comb begin
    sum         = A + B;
    diff        = A - B;
    shamt       = B[5:0];
    lt_signed   = ($signed(A) < $signed(B));
    lt_unsigned = (A < B);
  end

  // Operation select; undefined codes yield zero with no overflow.
  always_comb begin
    result     = 64'd0;
    result_ovf = 1'b0;
    case (OP)
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_ADD: begin
        result     = sum;
        result_ovf = (A[63] == B[63]) && (sum[63] != A[63]);
      end
      OP_XOR:  result = A ^ B;
      OP_SLL:  result = A << shamt;
      OP_SRL:  result = A >> shamt;
      OP_SUB: begin
        result     = diff;
        result_ovf = (A[63] != B[63]) && (diff[63] != A[63]);
      end
      OP_SLT:  result = {63'd0, lt_signed};
      OP_SRA:  result = $unsigned($signed(A) >>> shamt);
      OP_SLTU: result = {63'd0, lt_unsigned};
      OP_NOR:  result = ~(A | B);
      default: begin
        result     = 64'd0;
        result_ovf = 1'b0;
      end
    endcase
  end

  // Result/flag registers load only on valid input; out_valid marks a fresh result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      O         <= 64'd0;
      Ovf       <= 1'b0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        O    <= result;
        Ovf  <= result_ovf;
        Zero <= (result == 64'd0);
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  OP;
  logic        in_valid;
  logic [63:0] O;
  logic        Ovf;
  logic        Zero;
  logic        out_valid;

  int tests;
  int fails;

  alu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .in_valid  (in_valid),
    .O         (O),
    .Ovf       (Ovf),
    .Zero      (Zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for a single edge, then sample 1ns after that edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    A = a; B = b; OP = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (O !== 64'd0) begin fails++; $display("FAIL reset_O got=%h exp=%h", O, 64'd0); end
    tests++; if (Ovf !== 1'b0) begin fails++; $display("FAIL reset_Ovf got=%b exp=0", Ovf); end
    tests++; if (Zero !== 1'b1) begin fails++; $display("FAIL reset_Zero got=%b exp=1", Zero); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_add;
    issue(64'd2, 64'd16, 4'b0010);
    tests++; if (O !== 64'd18) begin fails++; $display("FAIL add_O got=%h exp=%h", O, 64'd18); end
    tests++; if (Zero !== 1'b0) begin fails++; $display("FAIL add_Zero got=%b exp=0", Zero); end
    tests++; if (Ovf !== 1'b0) begin fails++; $display("FAIL add_Ovf got=%b exp=0", Ovf); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
  endtask

  task automatic test_overflow;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    tests++; if (O !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL add_ovf_O got=%h exp=8000000000000000", O); end
    tests++; if (Ovf !== 1'b1) begin fails++; $display("FAIL add_ovf_Ovf got=%b exp=1", Ovf); end
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0110);
    tests++; if (O !== 64'h7FFF_FFFF_FFFF_FFFE) begin fails++; $display("FAIL sub_O got=%h exp=7ffffffffffffffe", O); end
    tests++; if (Ovf !== 1'b0) begin fails++; $display("FAIL sub_Ovf got=%b exp=0", Ovf); end
    issue(64'h8000_0000_0000_0000, 64'd1, 4'b0110);
    tests++; if (O !== 64'h7FFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL sub_ovf_O got=%h exp=7fffffffffffffff", O); end
    tests++; if (Ovf !== 1'b1) begin fails++; $display("FAIL sub_ovf_Ovf got=%b exp=1", Ovf); end
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    tests++; if (O !== 64'd0 || Zero !== 1'b1 || Ovf !== 1'b0) begin fails++; $display("FAIL add_wrap got O=%h Z=%b V=%b exp O=0 Z=1 V=0", O, Zero, Ovf); end
  endtask

  task automatic test_zero;
    issue(64'd5, 64'd5, 4'b0110);
    tests++; if (O !== 64'd0) begin fails++; $display("FAIL sub_zero_O got=%h exp=0", O); end
    tests++; if (Zero !== 1'b1) begin fails++; $display("FAIL sub_zero_Zero got=%b exp=1", Zero); end
  endtask

  task automatic test_logic;
    issue(64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00FF, 4'b0000);
    tests++; if (O !== 64'h00F0_0000_00FF_0034) begin fails++; $display("FAIL and_O got=%h exp=00f00000_00ff0034", O); end
    issue(64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00FF, 4'b0001);
    tests++; if (O !== 64'hFFF0_FFFF_FFFF_12FF) begin fails++; $display("FAIL or_O got=%h exp=fff0ffff_ffff12ff", O); end
    issue(64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00FF, 4'b0011);
    tests++; if (O !== 64'hFF00_FFFF_FF00_12CB) begin fails++; $display("FAIL xor_O got=%h exp=ff00ffff_ff0012cb", O); end
    issue(64'd0, 64'd0, 4'b1100);
    tests++; if (O !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL nor_O got=%h exp=all ones", O); end
    tests++; if (Zero !== 1'b0) begin fails++; $display("FAIL nor_Zero got=%b exp=0", Zero); end
  endtask

  task automatic test_compare;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0111);
    tests++; if (O !== 64'd1) begin fails++; $display("FAIL slt_O got=%h exp=1", O); end
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001);
    tests++; if (O !== 64'd0 || Zero !== 1'b1) begin fails++; $display("FAIL sltu_O got=%h Z=%b exp O=0 Z=1", O, Zero); end
    issue(64'h8000_0000_0000_0000, 64'd1, 4'b0111);
    tests++; if (O !== 64'd1) begin fails++; $display("FAIL slt_ovf_O got=%h exp=1", O); end
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111);
    tests++; if (O !== 64'd0) begin fails++; $display("FAIL slt_pos_neg_O got=%h exp=0", O); end
    issue(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001);
    tests++; if (O !== 64'd1 || Ovf !== 1'b0) begin fails++; $display("FAIL sltu_true got O=%h V=%b exp O=1 V=0", O, Ovf); end
  endtask

  task automatic test_shift;
    issue(64'h8000_0000_0000_0000, 64'h41, 4'b1000);
    tests++; if (O !== 64'hC000_0000_0000_0000) begin fails++; $display("FAIL sra_O got=%h exp=c000000000000000", O); end
    issue(64'h8000_0000_0000_0000, 64'h41, 4'b0101);
    tests++; if (O !== 64'h4000_0000_0000_0000) begin fails++; $display("FAIL srl_O got=%h exp=4000000000000000", O); end
    issue(64'd1, 64'd63, 4'b0100);
    tests++; if (O !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL sll_O got=%h exp=8000000000000000", O); end
    issue(64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_FFC4, 4'b0100);
    tests++; if (O !== 64'h0000_0000_0000_0F00) begin fails++; $display("FAIL sll_hi_ignored got=%h exp=f00", O); end
    issue(64'h7000_0000_0000_0000, 64'd60, 4'b1000);
    tests++; if (O !== 64'd7) begin fails++; $display("FAIL sra_pos got=%h exp=7", O); end
  endtask

  task automatic test_hold;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    A = 64'd9; B = 64'd9; OP = 4'b0110;
    @(posedge clk); #1;
    tests++; if (O !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL hold_O got=%h exp=8000000000000000", O); end
    tests++; if (Ovf !== 1'b1 || Zero !== 1'b0) begin fails++; $display("FAIL hold_flags got V=%b Z=%b exp V=1 Z=0", Ovf, Zero); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_undefined;
    issue(64'd123, 64'd456, 4'b1111);
    tests++; if (O !== 64'd0 || Zero !== 1'b1 || Ovf !== 1'b0) begin fails++; $display("FAIL op1111 got O=%h Z=%b V=%b exp O=0 Z=1 V=0", O, Zero, Ovf); end
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1010);
    tests++; if (O !== 64'd0 || Zero !== 1'b1 || Ovf !== 1'b0) begin fails++; $display("FAIL op1010 got O=%h Z=%b V=%b exp O=0 Z=1 V=0", O, Zero, Ovf); end
  endtask

  task automatic test_back_to_back;
    A = 64'd10; B = 64'd3; OP = 4'b0110; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (O !== 64'd7 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_0 got O=%h ov=%b exp O=7 ov=1", O, out_valid); end
    A = 64'd10; B = 64'd3; OP = 4'b0010;
    @(posedge clk); #1;
    tests++; if (O !== 64'd13 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_1 got O=%h ov=%b exp O=13 ov=1", O, out_valid); end
    A = 64'd3; B = 64'd10; OP = 4'b0111;
    @(posedge clk); #1;
    tests++; if (O !== 64'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_2 got O=%h ov=%b exp O=1 ov=1", O, out_valid); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (O !== 64'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got O=%h ov=%b exp O=1 ov=0", O, out_valid); end
  endtask

  task automatic test_async_reset;
    A = 64'd3; B = 64'd4; OP = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (O !== 64'd7) begin fails++; $display("FAIL pre_reset_O got=%h exp=7", O); end
    A = 64'd100; B = 64'd1;
    #2 reset = 1'b1;
    #1;
    tests++; if (O !== 64'd0 || Zero !== 1'b1 || Ovf !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL async_reset got O=%h Z=%b V=%b ov=%b exp O=0 Z=1 V=0 ov=0", O, Zero, Ovf, out_valid); end
    @(posedge clk); #1;
    tests++; if (O !== 64'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_discard got O=%h ov=%b exp O=0 ov=0", O, out_valid); end
    reset = 1'b0;
    A = 64'd10; B = 64'd20; OP = 4'b0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (O !== 64'd30 || out_valid !== 1'b1 || Zero !== 1'b0) begin fails++; $display("FAIL post_reset got O=%h ov=%b Z=%b exp O=30 ov=1 Z=0", O, out_valid, Zero); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    A = 64'd0; B = 64'd0; OP = 4'd0; in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    test_reset;
    reset = 1'b0;
    test_add;
    test_overflow;
    test_zero;
    test_logic;
    test_compare;
    test_shift;
    test_hold;
    test_undefined;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
